// File: rtl/des_pkg.sv
// Shared DES constants, FSM state type and small permutation helpers for the
// iterative DES engine and its combinational sub-blocks.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Per-round key rotation amounts, indexed by round counter
  localparam logic [1:0] SHIFT_DEC [0:15] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] SHIFT_ENC [0:15] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Tables hold 1-based DES bit numbers
  localparam int IP_TABLE [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IP_INV_TABLE [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

  localparam int PC1_TABLE [0:55] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};

  localparam int PC2_TABLE [0:47] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TABLE [0:47] = '{
    32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
    8,  9,  10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int P_TABLE [0:31] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
    2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};

  // Each box is stored row-major: index = row*16 + column
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] o;
    for (int i = 0; i < 56; i++) o[i] = k[PC1_TABLE[i] - 1];
    return o;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[i] = cd[PC2_TABLE[i] - 1];
    return o;
  endfunction

  function automatic logic [0:47] e_expand(input logic [0:31] r);
    logic [0:47] o;
    for (int i = 0; i < 48; i++) o[i] = r[E_TABLE[i] - 1];
    return o;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] s);
    logic [0:31] o;
    for (int i = 0; i < 32; i++) o[i] = s[P_TABLE[i] - 1];
    return o;
  endfunction

  // Bit 0 is DES bit 1, so "left" moves bits toward index 0
  function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] s);
    case (s)
      2'd1:    return {x[1:27], x[0]};
      2'd2:    return {x[2:27], x[0:1]};
      default: return x;
    endcase
  endfunction

  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] s);
    case (s)
      2'd1:    return {x[27], x[0:26]};
      2'd2:    return {x[26:27], x[0:25]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K): expansion, key mix, S-box substitution, P permutation.
module des_f_function
  import des_pkg::*;
(
  input  logic [0:31] r,
  input  logic [0:47] subkey,
  output logic [0:31] result
);

  logic [0:47] mixed;
  logic [0:31] s_out;

  // Row comes from the outer bits of each 6-bit group, column from the inner four
  always_comb begin
    mixed = e_expand(r) ^ subkey;
    s_out = '0;
    for (int j = 0; j < 8; j++) begin
      s_out[4*j +: 4] = 4'(SBOX[j][{mixed[6*j], mixed[6*j+5], mixed[6*j+1 +: 4]}]);
    end
    result = p_perm(s_out);
  end

endmodule

// File: rtl/des_initial_permutation.sv
// DES initial permutation IP, purely combinational.
module des_initial_permutation
  import des_pkg::*;
(
  input  logic [0:63] block,
  output logic [0:63] permuted
);

  always_comb begin
    permuted = '0;
    for (int i = 0; i < 64; i++) permuted[i] = block[IP_TABLE[i] - 1];
  end

endmodule

// File: rtl/des_inverse_initial_permutation.sv
// DES final permutation IP^-1, purely combinational.
module des_inverse_initial_permutation
  import des_pkg::*;
(
  input  logic [0:63] block,
  output logic [0:63] permuted
);

  always_comb begin
    permuted = '0;
    for (int i = 0; i < 64; i++) permuted[i] = block[IP_INV_TABLE[i] - 1];
  end

endmodule

// File: rtl/des_iterative_decrypt.sv
// Iterative DES decryptor: one Feistel round per clock, subkeys derived on the fly.
// Define DES_ENCRYPT_MODE_EN to add the encrypt port and a left-rotating key schedule.
module des_iterative_decrypt
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] input_block,
  input  logic [0:63] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] output_block
`ifdef DES_ENCRYPT_MODE_EN
  ,
  input  logic        encrypt
`endif
);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [0:31] l, r;
  logic [0:27] c, d, c_rot, d_rot;
  logic [0:47] subkey;
  logic [0:31] f_result;
  logic [0:63] ip_block;
  logic        accept;

`ifdef DES_ENCRYPT_MODE_EN
  logic        mode;
`endif

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ROUND;
      ROUND:   if (cnt == 4'd15) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Decrypt walks the schedule backwards, so round 0 reuses C0/D0 unrotated (K16)
  always_comb begin
    c_rot = rotr28(c, SHIFT_DEC[cnt]);
    d_rot = rotr28(d, SHIFT_DEC[cnt]);
`ifdef DES_ENCRYPT_MODE_EN
    if (mode) begin
      c_rot = rotl28(c, SHIFT_ENC[cnt]);
      d_rot = rotl28(d, SHIFT_ENC[cnt]);
    end
`endif
  end

  assign subkey = pc2({c_rot, d_rot});

  des_initial_permutation u_ip (
    .block    (input_block),
    .permuted (ip_block)
  );

  des_f_function u_f (
    .r      (r),
    .subkey (subkey),
    .result (f_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      l   <= '0;
      r   <= '0;
      c   <= '0;
      d   <= '0;
      cnt <= '0;
`ifdef DES_ENCRYPT_MODE_EN
      mode <= 1'b0;
`endif
    end else if (accept) begin
      {l, r} <= ip_block;
      {c, d} <= pc1(key);
      cnt    <= '0;
`ifdef DES_ENCRYPT_MODE_EN
      mode   <= encrypt;
`endif
    end else if (state == ROUND) begin
      c   <= c_rot;
      d   <= d_rot;
      l   <= r;
      r   <= l ^ f_result;
      cnt <= cnt + 4'd1;
    end
  end

  // Swapping to {R,L} undoes the last round's half exchange
  des_inverse_initial_permutation u_ip_inv (
    .block    ({r, l}),
    .permuted (output_block)
  );

endmodule

// File: tb/tb_des_iterative_decrypt.sv
// Scoreboard bench for des_iterative_decrypt: known-answer vectors, handshake corner
// cases and random blocks checked against a textbook DES model.
module tb_des_iterative_decrypt;
  import des_pkg::*;

  localparam logic [0:63] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [0:63] CT1  = 64'h85E813540F0AB405;
  localparam logic [0:63] PT1  = 64'h0123456789ABCDEF;
  localparam logic [0:63] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [0:63] CT2  = 64'h0000000000000000;
  localparam logic [0:63] PT2  = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, encrypt;
  logic [0:63] input_block, key, output_block;

  int          errors = 0;
  int          checks = 0;
  logic [0:63] exp_q[$];
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  des_iterative_decrypt dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_block  (input_block),
    .key          (key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_block (output_block)
`ifdef DES_ENCRYPT_MODE_EN
    ,
    .encrypt      (encrypt)
`endif
  );

  function automatic logic [0:63] rand64();
    return {$urandom, $urandom};
  endfunction

  // Textbook DES: full K1..K16 schedule up front, decryption applies it in reverse
  function automatic logic [0:63] des_ref(input logic [0:63] k, input logic [0:63] blk, input bit enc);
    logic [0:55] cd;
    logic [0:27] ch, dh;
    logic [0:47] ks [16];
    logic [0:47] ev;
    logic [0:63] x, y, o;
    logic [0:31] lh, rh, sv, fv, tmp;
    int          row, col;
    for (int i = 0; i < 56; i++) cd[i] = k[PC1_TABLE[i] - 1];
    ch = cd[0:27];
    dh = cd[28:55];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < ((n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2); s++) begin
        ch = {ch[1:27], ch[0]};
        dh = {dh[1:27], dh[0]};
      end
      cd = {ch, dh};
      for (int i = 0; i < 48; i++) ks[n][i] = cd[PC2_TABLE[i] - 1];
    end
    for (int i = 0; i < 64; i++) x[i] = blk[IP_TABLE[i] - 1];
    lh = x[0:31];
    rh = x[32:63];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++) ev[i] = rh[E_TABLE[i] - 1];
      ev = ev ^ (enc ? ks[n] : ks[15 - n]);
      for (int j = 0; j < 8; j++) begin
        row = 2 * int'(ev[6*j]) + int'(ev[6*j+5]);
        col = 8 * int'(ev[6*j+1]) + 4 * int'(ev[6*j+2]) + 2 * int'(ev[6*j+3]) + int'(ev[6*j+4]);
        sv[4*j +: 4] = 4'(SBOX[j][row * 16 + col]);
      end
      for (int i = 0; i < 32; i++) fv[i] = sv[P_TABLE[i] - 1];
      tmp = rh;
      rh  = lh ^ fv;
      lh  = tmp;
    end
    y = {rh, lh};
    for (int i = 0; i < 64; i++) o[i] = y[IP_INV_TABLE[i] - 1];
    return o;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic flag_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Presents a block and returns just after the accepting edge
  task automatic apply_stimulus(input logic [0:63] k, input logic [0:63] blk, input bit enc,
                                input bit push, input logic [0:63] expected);
    int waited = 0;
    @(posedge clk); #1;
    in_valid    = 1'b1;
    key         = k;
    input_block = blk;
    encrypt     = enc;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        flag_timeout("accept");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (push) exp_q.push_back(expected);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    key         = rand64();
    input_block = rand64();
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (cycles < 60) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (out_valid) return;
    end
    flag_timeout("wait_out_valid");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) return;
    end
    flag_timeout("drain");
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h with nothing expected at %0t", output_block, $time);
      end else begin
        check_output("scoreboard", output_block, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;
    logic [0:63] k, blk, ct;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    key = '0; input_block = '0; encrypt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_output_block", output_block, 64'd0);

    $display("[TB] known-answer decrypt vectors");
    apply_stimulus(KEY1, CT1, 1'b0, 1'b1, PT1);
    wait_out_valid(lat);
    check_output("latency", 64'(lat), 64'd16);
    wait_drain();
    apply_stimulus(KEY2, CT2, 1'b0, 1'b1, PT2);
    wait_drain();

    $display("[TB] back-pressure hold in DONE");
    @(posedge clk); #1 out_ready = 1'b0;
    apply_stimulus(KEY1, CT1, 1'b0, 1'b1, PT1);
    wait_out_valid(lat);
    @(posedge clk); #1;
    in_valid = 1'b1; key = KEY2; input_block = CT2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("hold_out_valid", 64'(out_valid), 64'd1);
      check_output("hold_output_block", output_block, PT1);
      check_output("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_output("handshake_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("post_handshake_in_ready", 64'(in_ready), 64'd1);
    check_output("post_handshake_out_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(PT2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("next_block_taken", 64'(in_ready), 64'd0);
    wait_drain();

    $display("[TB] reset during rounds");
    apply_stimulus(KEY1, CT1, 1'b0, 1'b0, '0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_output("abort_in_ready", 64'(in_ready), 64'd1);
    check_output("abort_out_valid", 64'(out_valid), 64'd0);
    check_output("abort_output_block", output_block, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_output("abort_no_output", 64'(seen), 64'd0);
    apply_stimulus(KEY1, CT1, 1'b0, 1'b1, PT1);
    wait_drain();

    $display("[TB] inputs churn while busy");
    apply_stimulus(KEY1, CT1, 1'b0, 1'b1, PT1);
    repeat (16) begin
      @(posedge clk); #1;
      key = rand64();
      input_block = rand64();
    end
    wait_drain();

    $display("[TB] random decrypt with random back-pressure");
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      k   = rand64();
      blk = rand64();
      apply_stimulus(k, blk, 1'b0, 1'b1, des_ref(k, blk, 1'b0));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

`ifdef DES_ENCRYPT_MODE_EN
    $display("[TB] encrypt mode and round trips");
    apply_stimulus(KEY1, PT1, 1'b1, 1'b1, CT1);
    apply_stimulus(KEY1, CT1, 1'b0, 1'b1, PT1);
    wait_drain();
    for (int i = 0; i < 1000; i++) begin
      k   = rand64();
      blk = rand64();
      ct  = des_ref(k, blk, 1'b1);
      apply_stimulus(k, blk, 1'b1, 1'b1, ct);
      apply_stimulus(k, ct, 1'b0, 1'b1, blk);
    end
    wait_drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
